// File: rtl/sot_frame_locker.sv
// Start-of-frame locker: finds the frame boundary in the start_of_frame sample and bit-slips
// every S-bit lane to match. Define FRAME_LOCKER_ERR_CNT_EN to add the sot_err_cnt counter.
module sot_frame_locker #(
    parameter int unsigned FRAME_SIZE = 8,
    parameter int unsigned N_LANES    = 8,
    parameter int unsigned SW         = $clog2(FRAME_SIZE)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [N_LANES*FRAME_SIZE-1:0]   sbits_i,
    input  logic [FRAME_SIZE-1:0]           start_of_frame,
    input  logic [11:0]                     aligned_count_to_ready,
    input  logic [3:0]                      miss_limit,
    output logic [N_LANES*FRAME_SIZE-1:0]   sbits_o,
    output logic [SW-1:0]                   bitslip_cnt_o,
    output logic                            sot_is_aligned,
    output logic                            sot_unstable
`ifdef FRAME_LOCKER_ERR_CNT_EN
    ,
    output logic [15:0]                     sot_err_cnt
`endif
);

    localparam int unsigned DW = N_LANES * FRAME_SIZE;

    typedef enum logic [1:0] {StSearch, StCount, StLocked} state_e;

    logic [FRAME_SIZE-1:0] sof_q;
    logic [DW-1:0]         din_q, din_p_q;
    state_e                state_q, state_d;
    logic [SW-1:0]         cand_q, cand_d;
    logic [11:0]           stable_q, stable_d;
    logic [3:0]            miss_q, miss_d;
    logic                  unstable_q, unstable_d;
    logic [DW-1:0]         sbits_q, sbits_d;
    logic [SW-1:0]         slip_q, slip_app;
`ifdef FRAME_LOCKER_ERR_CNT_EN
    logic [15:0]           err_q, err_d;
`endif

    logic                  sof_good;
    logic [SW-1:0]         sof_pos, dec_slip;
    logic                  match;
    logic [11:0]           stable_inc;
    logic [4:0]            miss_inc, miss_lim;

    // Slip decode: one-hot at bit p means the frame starts p+1 bits into the sample.
    always_comb begin
        sof_good = (sof_q != '0) && ((sof_q & (sof_q - FRAME_SIZE'(1))) == '0);
        sof_pos  = '0;
        for (int i = 0; i < FRAME_SIZE; i++) begin
            if (sof_q[i]) sof_pos = SW'(i);
        end
        dec_slip = sof_good ? (sof_pos + SW'(1)) : SW'(1);
    end

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        stable_d   = stable_q;
        miss_d     = miss_q;
        unstable_d = unstable_q;
        slip_app   = cand_q;
`ifdef FRAME_LOCKER_ERR_CNT_EN
        err_d      = err_q;
`endif
        match      = sof_good && (dec_slip == cand_q);
        stable_inc = stable_q + 12'd1;
        miss_inc   = {1'b0, miss_q} + 5'd1;
        miss_lim   = (miss_limit == 4'd0) ? 5'd1 : {1'b0, miss_limit};

        unique case (state_q)
            StSearch: begin
                slip_app = dec_slip;
                if (sof_good) begin
                    cand_d   = dec_slip;
                    stable_d = '0;
                    state_d  = StCount;
                end
            end
            StCount: begin
                // A threshold already met (e.g. zero) locks before looking at the frame.
                if (stable_q == aligned_count_to_ready) begin
                    state_d = StLocked;
                end else if (match) begin
                    stable_d = stable_inc;
                    if (stable_inc == aligned_count_to_ready) state_d = StLocked;
                end else if (sof_good) begin
                    cand_d   = dec_slip;
                    stable_d = '0;
                end else begin
                    state_d = StSearch;
                end
            end
            StLocked: begin
                if (match) begin
                    miss_d = '0;
                end else begin
`ifdef FRAME_LOCKER_ERR_CNT_EN
                    if (err_q != 16'hffff) err_d = err_q + 16'd1;
`endif
                    if (miss_inc >= miss_lim) begin
                        state_d    = StSearch;
                        miss_d     = '0;
                        unstable_d = 1'b1;
                    end else begin
                        miss_d = miss_inc[3:0];
                    end
                end
            end
            default: state_d = StSearch;
        endcase
    end

    // Per-lane barrel shift over the current and previous frame.
    logic [2*FRAME_SIZE-1:0] lane_cat, lane_shift;
    always_comb begin
        sbits_d    = '0;
        lane_cat   = '0;
        lane_shift = '0;
        for (int k = 0; k < N_LANES; k++) begin
            lane_cat   = {din_q[FRAME_SIZE*k +: FRAME_SIZE], din_p_q[FRAME_SIZE*k +: FRAME_SIZE]};
            lane_shift = lane_cat >> slip_app;
            sbits_d[FRAME_SIZE*k +: FRAME_SIZE] = lane_shift[FRAME_SIZE-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sof_q      <= '0;
            din_q      <= '0;
            din_p_q    <= '0;
            state_q    <= StSearch;
            cand_q     <= SW'(1);
            stable_q   <= '0;
            miss_q     <= '0;
            unstable_q <= 1'b0;
            sbits_q    <= '0;
            slip_q     <= '0;
`ifdef FRAME_LOCKER_ERR_CNT_EN
            err_q      <= '0;
`endif
        end else begin
            sof_q      <= start_of_frame;
            din_q      <= sbits_i;
            din_p_q    <= din_q;
            state_q    <= state_d;
            cand_q     <= cand_d;
            stable_q   <= stable_d;
            miss_q     <= miss_d;
            unstable_q <= unstable_d;
            sbits_q    <= sbits_d;
            slip_q     <= slip_app;
`ifdef FRAME_LOCKER_ERR_CNT_EN
            err_q      <= err_d;
`endif
        end
    end

    assign sbits_o        = sbits_q;
    assign bitslip_cnt_o  = slip_q;
    assign sot_is_aligned = (state_q == StLocked);
    assign sot_unstable   = unstable_q;
`ifdef FRAME_LOCKER_ERR_CNT_EN
    assign sot_err_cnt    = err_q;
`endif

endmodule
